// File: rtl/mips_pkg.sv
// Shared MIPS-31 encodings, ALU operation enum and the reset vector used by
// the single-cycle core and its SoC wrapper.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

endpackage

// File: rtl/mips_sccomp_soc_if.sv
// Core-to-memory bus: instruction fetch port, data port, and an instruction
// load hook for a boot loader (tied off in this SoC).
interface mips_sccomp_soc_if;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dwe;

  modport master (output iaddr, daddr, dwdata, dwe, input idata, drdata);
  modport imem_slave (input iaddr, ld_we, ld_addr, ld_data, output idata);
  modport dmem_slave (input daddr, dwdata, dwe, output drdata);
endinterface

// File: rtl/mips_dram.sv
// Data RAM: word-only accesses, combinational read, write on the rising edge.
module mips_dram #(
  parameter int DEPTH = 2048
) (
  input  logic                  clk,
  mips_sccomp_soc_if.dmem_slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] data_array [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (bus.dwe) data_array[bus.daddr[AW+1:2]] <= bus.dwdata;
  end

  assign bus.drdata = data_array[bus.daddr[AW+1:2]];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.daddr[31:AW+2], bus.daddr[1:0]};

endmodule

// File: rtl/mips_iram.sv
// Instruction RAM: word-indexed combinational fetch; upper PC bits ignored.
module mips_iram #(
  parameter int DEPTH = 2048
) (
  input  logic                  clk,
  mips_sccomp_soc_if.imem_slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] inst_array [0:DEPTH-1];

  // NOTE: memory arrays carry no reset; contents survive a core reset.
  always_ff @(posedge clk) begin
    if (bus.ld_we) inst_array[bus.ld_addr[AW+1:2]] <= bus.ld_data;
  end

  assign bus.idata = inst_array[bus.iaddr[AW+1:2]];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.iaddr[31:AW+2], bus.iaddr[1:0],
                              bus.ld_addr[31:AW+2], bus.ld_addr[1:0]};

endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port; $0 is hard-wired to zero and reset clears every register.
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  waddr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] array_reg [0:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) array_reg[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      array_reg[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge value, so a same-cycle write returns old data.
  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : array_reg[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : array_reg[raddr2];

endmodule

// File: rtl/mips_sccpu.sv
// Single-cycle MIPS-31 core: decode, ALU and next-PC logic around the
// register file; every instruction commits on the next rising edge.
module mips_sccpu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = mips_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  mips_sccomp_soc_if.master bus,
  output logic [31:0]       pc
);

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target;

  assign instr  = bus.idata;
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];
  assign target = instr[25:0];

  alu_op_e alu_op;
  logic use_imm, zext, var_sh, reg_we, wr_rt, link, load, store, ovf_chk;
  logic br_eq, br_ne, jump, jump_reg;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    alu_op = ALU_ADD;
    use_imm = 1'b0; zext = 1'b0; var_sh = 1'b0; reg_we = 1'b0; wr_rt = 1'b0;
    link = 1'b0; load = 1'b0; store = 1'b0; ovf_chk = 1'b0;
    br_eq = 1'b0; br_ne = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          FN_ADD:  ovf_chk = 1'b1;
          FN_ADDU: ;
          FN_SUB:  begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_SLLV: begin alu_op = ALU_SLL; var_sh = 1'b1; end
          FN_SRLV: begin alu_op = ALU_SRL; var_sh = 1'b1; end
          FN_SRAV: begin alu_op = ALU_SRA; var_sh = 1'b1; end
          FN_JR:   begin reg_we = 1'b0; jump_reg = 1'b1; end
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI:  begin use_imm = 1'b1; wr_rt = 1'b1; reg_we = 1'b1; ovf_chk = 1'b1; end
      OP_ADDIU: begin use_imm = 1'b1; wr_rt = 1'b1; reg_we = 1'b1; end
      OP_SLTI:  begin use_imm = 1'b1; wr_rt = 1'b1; reg_we = 1'b1; alu_op = ALU_SLT; end
      OP_SLTIU: begin use_imm = 1'b1; wr_rt = 1'b1; reg_we = 1'b1; alu_op = ALU_SLTU; end
      OP_ANDI:  begin use_imm = 1'b1; zext = 1'b1; wr_rt = 1'b1; reg_we = 1'b1; alu_op = ALU_AND; end
      OP_ORI:   begin use_imm = 1'b1; zext = 1'b1; wr_rt = 1'b1; reg_we = 1'b1; alu_op = ALU_OR; end
      OP_XORI:  begin use_imm = 1'b1; zext = 1'b1; wr_rt = 1'b1; reg_we = 1'b1; alu_op = ALU_XOR; end
      OP_LUI:   begin wr_rt = 1'b1; reg_we = 1'b1; alu_op = ALU_LUI; end
      OP_LW:    begin use_imm = 1'b1; wr_rt = 1'b1; reg_we = 1'b1; load = 1'b1; end
      OP_SW:    begin use_imm = 1'b1; store = 1'b1; end
      OP_BEQ:   br_eq = 1'b1;
      OP_BNE:   br_ne = 1'b1;
      OP_J:     jump = 1'b1;
      OP_JAL:   begin jump = 1'b1; link = 1'b1; reg_we = 1'b1; end
      default:  ;
    endcase
  end

  logic [31:0] rs_val, rt_val, imm_ext, op_b, alu_r;
  logic [4:0]  sh;
  logic        ovf;

  assign imm_ext = zext ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};
  assign op_b    = use_imm ? imm_ext : rt_val;
  assign sh      = var_sh ? rs_val[4:0] : shamt;

  always_comb begin
    alu_r = '0;
    case (alu_op)
      ALU_ADD:  alu_r = rs_val + op_b;
      ALU_SUB:  alu_r = rs_val - op_b;
      ALU_AND:  alu_r = rs_val & op_b;
      ALU_OR:   alu_r = rs_val | op_b;
      ALU_XOR:  alu_r = rs_val ^ op_b;
      ALU_NOR:  alu_r = ~(rs_val | op_b);
      ALU_SLT:  alu_r = {31'd0, $signed(rs_val) < $signed(op_b)};
      ALU_SLTU: alu_r = {31'd0, rs_val < op_b};
      ALU_SLL:  alu_r = op_b << sh;
      ALU_SRL:  alu_r = op_b >> sh;
      ALU_SRA:  alu_r = $signed(op_b) >>> sh;
      ALU_LUI:  alu_r = {imm16, 16'd0};
      default:  alu_r = '0;
    endcase
  end

  // Signed overflow: operands agree in sign (add) or differ (sub) and the result flips.
  always_comb begin
    ovf = 1'b0;
    if (ovf_chk) begin
      if (alu_op == ALU_SUB) ovf = (rs_val[31] != op_b[31]) && (alu_r[31] != rs_val[31]);
      else                   ovf = (rs_val[31] == op_b[31]) && (alu_r[31] != rs_val[31]);
    end
  end

  logic [31:0] pc_plus4, next_pc, wr_data;
  logic [4:0]  wr_addr;
  logic        wr_en;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg)                                    next_pc = rs_val;
    else if (jump)                                   next_pc = {pc_plus4[31:28], target, 2'b00};
    else if ((br_eq && rs_val == rt_val) || (br_ne && rs_val != rt_val))
                                                     next_pc = pc_plus4 + {imm_ext[29:0], 2'b00};
  end

  assign wr_addr = link ? 5'd31 : (wr_rt ? rt : rd);
  assign wr_data = link ? pc_plus4 : (load ? bus.drdata : alu_r);
  assign wr_en   = reg_we && !ovf;

  mips_regfile cpu_ref (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs),
    .raddr2 (rt),
    .waddr  (wr_addr),
    .we     (wr_en),
    .wdata  (wr_data),
    .rdata1 (rs_val),
    .rdata2 (rt_val)
  );

  assign bus.iaddr  = pc;
  assign bus.daddr  = alu_r;
  assign bus.dwdata = rt_val;
  assign bus.dwe    = store && !reset;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_VEC;
    else       pc <= next_pc;
  end

endmodule

// File: rtl/mips_sccomp_soc.sv
// Single-cycle MIPS SoC: core plus instruction and data RAMs, with PC and
// fetched instruction exported for trace logging.
module mips_sccomp_soc #(
  parameter int          IMEM_DEPTH = 2048,
  parameter int          DMEM_DEPTH = 2048,
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC
) (
  input  logic        clk_in,
  input  logic        reset,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  mips_sccomp_soc_if bus ();

  assign bus.ld_we   = 1'b0;
  assign bus.ld_addr = '0;
  assign bus.ld_data = '0;

  mips_sccpu #(.RESET_VEC(RESET_PC)) sccpu (
    .clk   (clk_in),
    .reset (reset),
    .bus   (bus.master),
    .pc    (pc)
  );

  mips_iram #(.DEPTH(IMEM_DEPTH)) iram_inst (
    .clk (clk_in),
    .bus (bus.imem_slave)
  );

  mips_dram #(.DEPTH(DMEM_DEPTH)) dram_inst (
    .clk (clk_in),
    .bus (bus.dmem_slave)
  );

  assign inst = bus.idata;

endmodule

// File: tb/tb_mips_sccomp_soc.sv
// Directed bench for mips_sccomp_soc: each vector is placed at the expected PC,
// clocked once, then PC and one register or DRAM word are compared.
module tb_mips_sccomp_soc;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] inst, pc;

  always #5 clk_in = ~clk_in;

  mips_sccomp_soc dut (
    .clk_in (clk_in),
    .reset  (reset),
    .inst   (inst),
    .pc     (pc)
  );

  // Trace view of the fetch port, fed from the exported SoC outputs.
  mips_sccomp_soc_if trace_if ();
  assign trace_if.iaddr = pc;
  assign trace_if.idata = inst;

  typedef struct {
    logic [31:0] instr;
    bit          is_mem;
    int          idx;
    logic [31:0] exp_val;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sa, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, logic [31:0] addr);
    return {op, addr[27:2]};
  endfunction

  function automatic vec_t v(logic [31:0] instr, bit is_mem, int idx,
                             logic [31:0] exp_val, logic [31:0] exp_pc);
    vec_t r;
    r.instr = instr; r.is_mem = is_mem; r.idx = idx; r.exp_val = exp_val; r.exp_pc = exp_pc;
    return r;
  endfunction

  function automatic int widx(logic [31:0] addr);
    return int'(addr[12:2]);
  endfunction

  initial begin
    logic [31:0] cur_pc;
    logic [31:0] act;
    logic [31:0] sw_instr;
    int          nonzero;

    vecs.push_back(v(enc_i(6'h08, 0, 1, 16'd5),       0, 1,  32'd5,        32'h0040_0004));
    vecs.push_back(v(enc_i(6'h08, 0, 2, 16'hFFFD),    0, 2,  32'hFFFF_FFFD, 32'h0040_0008));
    vecs.push_back(v(enc_r(1, 2, 3, 0, 6'h20),        0, 3,  32'd2,        32'h0040_000C));
    vecs.push_back(v(enc_i(6'h08, 0, 0, 16'd7),       0, 0,  32'd0,        32'h0040_0010));
    vecs.push_back(v(enc_i(6'h04, 0, 0, 16'd2),       0, 3,  32'd2,        32'h0040_001C));
    vecs.push_back(v(enc_i(6'h05, 1, 1, 16'd5),       0, 1,  32'd5,        32'h0040_0020));
    vecs.push_back(v(enc_j(6'h03, 32'h0040_0100),     0, 31, 32'h0040_0024, 32'h0040_0100));
    vecs.push_back(v(enc_r(31, 0, 0, 0, 6'h08),       0, 31, 32'h0040_0024, 32'h0040_0024));
    vecs.push_back(v(enc_i(6'h0F, 0, 4, 16'h1234),    0, 4,  32'h1234_0000, 32'h0040_0028));
    vecs.push_back(v(enc_i(6'h0D, 4, 4, 16'h5678),    0, 4,  32'h1234_5678, 32'h0040_002C));
    vecs.push_back(v(enc_i(6'h0F, 0, 5, 16'h8000),    0, 5,  32'h8000_0000, 32'h0040_0030));
    vecs.push_back(v(enc_r(0, 5, 6, 4, 6'h03),        0, 6,  32'hF800_0000, 32'h0040_0034));
    vecs.push_back(v(enc_r(0, 5, 7, 4, 6'h02),        0, 7,  32'h0800_0000, 32'h0040_0038));
    vecs.push_back(v(enc_i(6'h08, 0, 8, 16'hFFFF),    0, 8,  32'hFFFF_FFFF, 32'h0040_003C));
    vecs.push_back(v(enc_i(6'h08, 0, 10, 16'd1),      0, 10, 32'd1,        32'h0040_0040));
    vecs.push_back(v(enc_r(8, 10, 11, 0, 6'h2A),      0, 11, 32'd1,        32'h0040_0044));
    vecs.push_back(v(enc_r(8, 10, 10, 0, 6'h2B),      0, 10, 32'd0,        32'h0040_0048));
    vecs.push_back(v(enc_i(6'h0C, 8, 12, 16'h8001),   0, 12, 32'h0000_8001, 32'h0040_004C));
    vecs.push_back(v(enc_i(6'h0E, 4, 13, 16'hFFFF),   0, 13, 32'h1234_A987, 32'h0040_0050));
    vecs.push_back(v(enc_r(0, 0, 14, 0, 6'h27),       0, 14, 32'hFFFF_FFFF, 32'h0040_0054));
    vecs.push_back(v(enc_r(1, 12, 15, 0, 6'h04),      0, 15, 32'h0010_0020, 32'h0040_0058));
    vecs.push_back(v(enc_r(1, 5, 16, 0, 6'h07),       0, 16, 32'hFC00_0000, 32'h0040_005C));
    vecs.push_back(v(enc_r(1, 3, 17, 0, 6'h22),       0, 17, 32'd3,        32'h0040_0060));
    vecs.push_back(v(enc_i(6'h0A, 8, 18, 16'd0),      0, 18, 32'd1,        32'h0040_0064));
    vecs.push_back(v(enc_i(6'h0B, 10, 19, 16'hFFFF),  0, 19, 32'd1,        32'h0040_0068));
    vecs.push_back(v(enc_i(6'h0F, 0, 20, 16'h1001),   0, 20, 32'h1001_0000, 32'h0040_006C));
    vecs.push_back(v(enc_i(6'h0F, 0, 21, 16'hDEAD),   0, 21, 32'hDEAD_0000, 32'h0040_0070));
    vecs.push_back(v(enc_i(6'h0D, 21, 21, 16'hBEEF),  0, 21, 32'hDEAD_BEEF, 32'h0040_0074));
    vecs.push_back(v(enc_i(6'h2B, 20, 21, 16'd4),     1, 1,  32'hDEAD_BEEF, 32'h0040_0078));
    vecs.push_back(v(enc_i(6'h23, 20, 22, 16'd4),     0, 22, 32'hDEAD_BEEF, 32'h0040_007C));
    vecs.push_back(v(enc_i(6'h23, 20, 23, 16'd0),     0, 23, 32'd7,        32'h0040_0080));
    vecs.push_back(v(enc_i(6'h0F, 0, 24, 16'h7FFF),   0, 24, 32'h7FFF_0000, 32'h0040_0084));
    vecs.push_back(v(enc_i(6'h0D, 24, 24, 16'hFFFF),  0, 24, 32'h7FFF_FFFF, 32'h0040_0088));
    vecs.push_back(v(enc_r(24, 24, 2, 0, 6'h20),      0, 2,  32'hFFFF_FFFD, 32'h0040_008C));
    vecs.push_back(v(enc_r(24, 24, 2, 0, 6'h21),      0, 2,  32'hFFFF_FFFE, 32'h0040_0090));
    vecs.push_back(v(enc_i(6'h08, 24, 2, 16'd1),      0, 2,  32'hFFFF_FFFE, 32'h0040_0094));
    vecs.push_back(v(32'hFC42_0000,                   0, 2,  32'hFFFF_FFFE, 32'h0040_0098));
    vecs.push_back(v(enc_i(6'h09, 24, 26, 16'd1),     0, 26, 32'h8000_0000, 32'h0040_009C));
    vecs.push_back(v(enc_j(6'h02, 32'h0040_0000),     0, 26, 32'h8000_0000, 32'h0040_0000));

    // Reset: one edge with reset high.
    dut.iram_inst.inst_array[0] = vecs[0].instr;
    dut.dram_inst.data_array[0] = 32'd7;
    dut.dram_inst.data_array[2] = 32'h0000_0055;
    @(posedge clk_in);
    #1;
    check("reset_pc", pc, 32'h0040_0000);
    nonzero = 0;
    for (int r = 0; r < 32; r++)
      if (dut.sccpu.cpu_ref.array_reg[r] !== 32'd0) nonzero++;
    check("reset_regs_nonzero", 32'(nonzero), 32'd0);
    check("reset_inst", trace_if.idata, vecs[0].instr);
    @(negedge clk_in);
    reset = 1'b0;

    cur_pc = 32'h0040_0000;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk_in);
      dut.iram_inst.inst_array[widx(cur_pc)] = vecs[i].instr;
      #1;
      check($sformatf("fetch%0d", i), inst, vecs[i].instr);
      @(posedge clk_in);
      #1;
      check($sformatf("pc%0d", i), pc, vecs[i].exp_pc);
      if (vecs[i].is_mem) act = dut.dram_inst.data_array[vecs[i].idx];
      else                act = dut.sccpu.cpu_ref.array_reg[vecs[i].idx];
      check($sformatf("val%0d", i), act, vecs[i].exp_val);
      cur_pc = vecs[i].exp_pc;
    end

    // Mid-run reset on a store cycle: the store must be suppressed.
    sw_instr = enc_i(6'h2B, 20, 21, 16'd8);
    @(negedge clk_in);
    dut.iram_inst.inst_array[widx(cur_pc)] = sw_instr;
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    check("rst_sw_dram", dut.dram_inst.data_array[2], 32'h0000_0055);
    check("rst_sw_pc", pc, 32'h0040_0000);
    check("rst_sw_r21", dut.sccpu.cpu_ref.array_reg[21], 32'd0);
    check("rst_sw_r31", dut.sccpu.cpu_ref.array_reg[31], 32'd0);

    // Same store after release: $20=$21=0, so address 8 (word 2) gets 0.
    @(negedge clk_in);
    reset = 1'b0;
    @(posedge clk_in);
    #1;
    check("post_rst_sw_dram", dut.dram_inst.data_array[2], 32'd0);
    check("post_rst_sw_pc", pc, 32'h0040_0004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_sccomp_soc.md
Name: mips_sccomp_soc

Overview:
Single-cycle MIPS-31 computer, top-level SoC used by the system bench. It contains a one-instruction-per-clock CPU core, an instruction RAM (IRAM) and a data RAM (DRAM). The current PC and the fetched instruction are exported for trace logging. The bench preloads both memories and samples the register file through fixed hierarchical paths.

Parameters:
IMEM_DEPTH, 2048, IRAM words.
DMEM_DEPTH, 2048, DRAM words.
RESET_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
clk_in  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
inst  output  32  instruction fetched at the current PC (combinational).
pc  output  32  current program counter.

Behaviour:
- Clock and reset: one clock, clk_in. reset is synchronous and active-high.
- Required hierarchy, so the bench can preload and probe state:
  - IRAM instance iram_inst, array inst_array[0:IMEM_DEPTH-1].
  - DRAM instance dram_inst, array data_array[0:DMEM_DEPTH-1].
  - CPU instance sccpu, containing register-file instance cpu_ref with array array_reg[0:31].
  - All arrays are 32-bit wide.
- Reset, sampled on a rising edge with reset=1:
  - pc <= RESET_PC.
  - All 32 registers <= 0.
  - Memory contents are untouched.
- Fetch:
  - IRAM word index = pc[log2(IMEM_DEPTH)+1:2]; upper PC bits are ignored, so 0x00400000 maps to word 0.
  - inst is a combinational read of that word.
- Execute: the whole instruction completes in one cycle. At the rising edge the core commits PC, the register write and the DRAM write.
- Supported instructions:
  - R-type: add addu sub subu and or xor nor slt sltu sll srl sra sllv srlv srav jr.
  - I-type: addi addiu andi ori xori lui lw sw beq bne slti sltiu.
  - J-type: j jal.
- Unsupported opcode or funct: executes as a NOP (pc+4, no writes).
- Arithmetic and width rules:
  - Immediate sign-extension: addi, addiu, slti, sltiu, lw, sw, beq, bne.
  - Immediate zero-extension: andi, ori, xori.
  - lui writes imm<<16.
  - slt is a signed compare; sltu/sltiu are unsigned compares on the sign-extended immediate.
  - Shift amount: shamt for sll/srl/sra; rs[4:0] for the variable shifts.
  - add/addi/sub: on signed overflow the register write is suppressed. addu/subu wrap.
- Next PC:
  - Default: pc+4.
  - beq/bne taken: pc+4+(sext(imm)<<2).
  - j/jal: {pc+4[31:28], target, 2'b00}.
  - jal writes pc+4 to $31.
  - jr: pc <= rs.
- Register file:
  - Two combinational read ports, one write port on the rising edge.
  - $0 reads 0; writes to $0 are ignored.
  - A read in the same cycle as a write to that register returns the old value.
- DRAM:
  - Word index = addr[log2(DMEM_DEPTH)+1:2]; addr[1:0] and upper bits are ignored, so 0x10010000 maps to word 0.
  - Combinational read for lw.
  - sw writes on the rising edge.
  - Only word accesses.
- Reset asserted mid-program takes priority over all writes in that cycle: no register or DRAM write occurs.
- Out-of-range indices wrap naturally through the bit slicing.

Decomposition:
- Shared package mips_pkg:
  - Opcode and funct localparams.
  - ALU-op enum.
  - RESET_PC.
- Sub-modules:
  - One natural sub-module: mips_regfile (instance cpu_ref inside sccpu).
  - IRAM and DRAM are small array modules.
  - Decoder, ALU and next-PC logic live in the core.

Test Plan:
1. Reset: hold reset over one edge -> pc=0x00400000, every array_reg=0. inst equals inst_array[0].
2. addi/add: program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> after 3 edges $1=5, $2=0xFFFFFFFD, $3=2, pc=0x0040000C. Then addi $0,$0,7 leaves $0=0.
3. lui/ori/logic/shift:
   - lui $4,0x1234 then ori $4,$4,0x5678 -> $4=0x12345678.
   - sra of 0x80000000 by 4 -> 0xF8000000.
   - srl by 4 -> 0x08000000.
   - sltu 0xFFFFFFFF<1 -> 0; slt -> 1.
4. Memory: set $1=0x10010000 and $2=0xDEADBEEF; sw $2,4($1) -> data_array[1]=0xDEADBEEF. Then lw $3,4($1) -> $3=0xDEADBEEF. With data_array preloaded to word0=7, lw $5,0($1) -> $5=7.
5. Control flow:
   - beq $0,$0,+2 at 0x00400010 -> next pc=0x0040001C.
   - bne with equal regs -> pc+4.
   - jal 0x00400100 at 0x00400020 -> pc=0x00400100, $31=0x00400024.
   - jr $31 -> pc=0x00400024.
6. Overflow and mid-run reset:
   - $1=0x7FFFFFFF, add $2,$1,$1 -> $2 unchanged. addu $2,$1,$1 -> 0xFFFFFFFE.
   - Assert reset on a sw cycle -> DRAM unchanged, pc=0x00400000.
